// File: rtl/nec_frame_decoder_pkg.sv
// Shared NEC field layout, queue entry format and frame-check helpers.
package nec_frame_decoder_pkg;

  // Byte positions inside a 32-bit NEC burst.
  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned ADDRN_LSB = 8;
  localparam int unsigned CMD_LSB   = 16;
  localparam int unsigned CMDN_LSB  = 24;

  // Queue entry: {ext, addr16, cmd}.
  localparam int unsigned NEC_ENTRY_W = 25;

  typedef struct packed {
    logic        ext;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } nec_entry_t;

  typedef struct packed {
    logic        good;
    logic        ext;
    logic [15:0] addr16;
    logic [7:0]  cmd;
  } nec_check_t;

  // Parity check of a captured burst; an address pair that is not a true
  // inverse is read as a 16-bit extended address when that mode is enabled.
  function automatic nec_check_t nec_check(input logic [31:0] cap, input logic ext_en);
    nec_check_t res;
    logic       cmd_ok;
    logic       addr_ok;
    cmd_ok     = (cap[CMDN_LSB +: 8] == ~cap[CMD_LSB +: 8]);
    addr_ok    = (cap[ADDRN_LSB +: 8] == ~cap[ADDR_LSB +: 8]);
    res.ext    = !addr_ok && ext_en;
    res.good   = cmd_ok && (addr_ok || res.ext);
    res.addr16 = res.ext ? cap[ADDR_LSB +: 16] : {8'h00, cap[ADDR_LSB +: 8]};
    res.cmd    = cap[CMD_LSB +: 8];
    return res;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nec_fifo.sv
// Synchronous FIFO with registered storage; read data is the entry at the read pointer.
module nec_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same edge frees the slot, so a write on full is still taken.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage update; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nec_frame_decoder.sv
// Checks NEC bursts from the receiver, queues good frames and hands them out
// with a valid/ack handshake; keeps saturating debug counters.
module nec_frame_decoder
  import nec_frame_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          ADDR_EXT_EN   = 1'b1,
  parameter bit          ADDR_MATCH_EN = 1'b0,
  parameter logic [15:0] ADDR_MATCH    = 16'h00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] burst,
  input  logic        ready,
  output logic [15:0] out_addr,
  output logic [7:0]  out_cmd,
  output logic        out_ext,
  output logic        out_valid,
  input  logic        out_ack,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  logic [31:0] cap_q;
  logic        cap_vld_q;
  nec_check_t  chk;
  logic        filter_ok;
  logic        push;
  logic        bad;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  nec_entry_t  wr_entry;
  nec_entry_t  rd_entry;
  logic [7:0]  err_cnt_d, err_cnt_q;
  logic [7:0]  drop_cnt_d, drop_cnt_q;
  logic        overflow_d, overflow_q;

  // Capture stage: one burst per ready pulse, pipelined so back-to-back pulses work.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= ready;
      if (ready) begin
        cap_q <= burst;
      end
    end
  end

  assign chk       = nec_check(cap_q, ADDR_EXT_EN);
  assign filter_ok = !ADDR_MATCH_EN || (chk.addr16 == ADDR_MATCH);

  // Filtered frames fall through both push and bad, so they touch no counter.
  assign push = cap_vld_q && chk.good && filter_ok;
  assign bad  = cap_vld_q && !chk.good;
  assign pop  = out_ack && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  assign wr_entry.ext  = chk.ext;
  assign wr_entry.addr = chk.addr16;
  assign wr_entry.cmd  = chk.cmd;

  nec_fifo #(
    .WIDTH (NEC_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state for the saturating counters and sticky overflow flag.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (bad) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
      overflow_d = 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_addr  = rd_entry.addr;
  assign out_cmd   = rd_entry.cmd;
  assign out_ext   = rd_entry.ext;
  assign out_valid = !fifo_empty;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nec_frame_decoder.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_nec_frame_decoder;

  localparam int          DEPTH = 4;
  localparam bit          EXT   = 1'b1;
  localparam bit          MEN   = 1'b0;
  localparam logic [15:0] MVAL  = 16'h00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] burst;
  logic        ready;
  logic [15:0] out_addr;
  logic [7:0]  out_cmd;
  logic        out_ext;
  logic        out_valid;
  logic        out_ack;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nec_frame_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .ADDR_EXT_EN   (EXT),
    .ADDR_MATCH_EN (MEN),
    .ADDR_MATCH    (MVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .burst     (burst),
    .ready     (ready),
    .out_addr  (out_addr),
    .out_cmd   (out_cmd),
    .out_ext   (out_ext),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .err_cnt   (err_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // ---------------- reference model ----------------
  logic [24:0] mq[$];
  int          m_err = 0;
  int          m_drop = 0;
  bit          m_ovf = 0;
  bit          pend_v = 0;
  logic [31:0] pend;
  bit          started = 0;

  task automatic model_frame(input logic [31:0] b);
    logic [7:0]  a, an, c, cn;
    logic [15:0] addr;
    bit          aok, cok, ext, good;
    a  = b[7:0];   an = b[15:8];
    c  = b[23:16]; cn = b[31:24];
    cok  = ((c ^ cn) == 8'hFF);
    aok  = ((a ^ an) == 8'hFF);
    ext  = !aok && EXT;
    good = cok && (aok || ext);
    addr = ext ? {an, a} : {8'h00, a};
    if (!good) begin
      if (m_err < 255) m_err++;
    end else if (!MEN || addr == MVAL) begin
      if (mq.size() < DEPTH) mq.push_back({ext, addr, c});
      else begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      mq.delete();
      m_err = 0; m_drop = 0; m_ovf = 0; pend_v = 0; started = 1;
    end else if (started) begin
      if (out_ack && mq.size() > 0) void'(mq.pop_front());
      if (pend_v) model_frame(pend);
      pend_v = ready;
      pend   = burst;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("m_head", {7'd0, out_ext, out_addr, out_cmd}, {7'd0, mq[0]});
      end
      chk("m_err", {24'd0, err_cnt}, m_err);
      chk("m_drop", {24'd0, drop_cnt}, m_drop);
      chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] b);
    @(negedge clk);
    burst = b; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [7:0] abase, input logic [7:0] cbase);
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      burst = mk(abase + 8'(i), cbase + 8'(i));
      @(negedge clk);
    end
    ready = 1'b0;
  endtask

  task automatic ack_head(input string name, input logic [15:0] a, input logic [7:0] c);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_addr"}, {16'd0, out_addr}, {16'd0, a});
    chk({name, "_cmd"}, {24'd0, out_cmd}, {24'd0, c});
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; out_ack = 1'b0; burst = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);

    // 1) basic frame, latency 2
    send(32'hBF40_FD02);
    chk("t1_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_ext", {31'd0, out_ext}, 32'd0);
    ack_head("t1", 16'h0002, 8'h40);
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // 2) 5A/A5 is a true inverse pair: normal address. 5B/A5 is not: extended.
    send(32'hEF10_A55A);
    @(negedge clk);
    chk("t2a_ext", {31'd0, out_ext}, 32'd0);
    ack_head("t2a", 16'h005A, 8'h10);
    send(32'hEF10_A55B);
    @(negedge clk);
    chk("t2b_ext", {31'd0, out_ext}, 32'd1);
    chk("t2b_err", {24'd0, err_cnt}, 32'd0);
    ack_head("t2b", 16'hA55B, 8'h10);

    // 3) command parity error, then saturation
    send(32'hEE10_FD02);
    @(negedge clk);
    chk("t3_err1", {24'd0, err_cnt}, 32'd1);
    chk("t3_novalid", {31'd0, out_valid}, 32'd0);
    burst = 32'hEE10_FD02; ready = 1'b1;
    repeat (299) @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_sat", {24'd0, err_cnt}, 32'd255);

    // 4) five back-to-back good frames into a depth-4 queue
    send_n(5, 8'h01, 8'h10);
    @(negedge clk);
    chk("t4_drop", {24'd0, drop_cnt}, 32'd1);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    ack_head("t4_0", 16'h0001, 8'h10);
    ack_head("t4_1", 16'h0002, 8'h11);
    ack_head("t4_2", 16'h0003, 8'h12);
    ack_head("t4_3", 16'h0004, 8'h13);
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5) full queue: push and pop meet at the same edge
    send_n(4, 8'h21, 8'h31);
    @(negedge clk);
    burst = mk(8'h25, 8'h35); ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk("t5_drop", {24'd0, drop_cnt}, 32'd1);
    ack_head("t5_0", 16'h0022, 8'h32);
    ack_head("t5_1", 16'h0023, 8'h33);
    ack_head("t5_2", 16'h0024, 8'h34);
    ack_head("t5_3", 16'h0025, 8'h35);
    chk("t5_empty", {31'd0, out_valid}, 32'd0);

    // 6) reset mid-handshake with a frame in the capture stage
    send(mk(8'h30, 8'h40));
    @(negedge clk);
    burst = mk(8'h31, 8'h41); ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; rst = 1'b0; out_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1; out_ack = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_head", {7'd0, out_ext, out_addr, out_cmd}, 32'd0);
    chk("t6_err", {24'd0, err_cnt}, 32'd0);
    chk("t6_drop", {24'd0, drop_cnt}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_stay", {31'd0, out_valid}, 32'd0);
    send(mk(8'h44, 8'h55));
    @(negedge clk);
    ack_head("t6_new", 16'h0044, 8'h55);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
